// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loader for the 12-bit instruction memory, gates core_run on a valid image
module program_loader #(
  parameter int ADDR_W  = 2,
  parameter int INSTR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               core_run
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  // Word count is 9 bits wide so N=256 (ADDR_W=8) still fits.
  localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

  logic [2:0]         state_q, state_d;
  logic [7:0]         sum_q, sum_d;
  logic [8:0]         idx_q, idx_d;
  logic [8:0]         n_q, n_d;
  logic [3:0]         hi_q, hi_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               run_q, run_d;

  logic               in_session;
  logic               accept;
  logic [7:0]         sum_nx;
  logic [8:0]         idx_nx;

  assign in_session = (state_q == S_HDR) || (state_q == S_HI) ||
                      (state_q == S_LO)  || (state_q == S_CHK);
  assign accept     = in_valid && in_session;
  assign sum_nx     = sum_q + in_data;
  assign idx_nx     = idx_q + 9'd1;

  // Next-state logic: frame parsing, checksum accumulation and write generation
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    n_d       = n_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = err_q;
    run_d     = run_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          sum_d   = 8'd0;
          idx_d   = 9'd0;
          err_d   = 1'b0;
          run_d   = 1'b0;
        end
      end
      S_HDR: begin
        if (accept) begin
          sum_d = sum_nx;
          if (in_data == 8'd0 || {1'b0, in_data} > DEPTH) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            n_d     = {1'b0, in_data};
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (accept) begin
          sum_d = sum_nx;
          if (in_data[7:4] != 4'd0) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            hi_d    = in_data[3:0];
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          sum_d     = sum_nx;
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = {hi_q, in_data};
          idx_d     = idx_nx;
          state_d   = (idx_nx == n_q) ? S_CHK : S_HI;
        end
      end
      S_CHK: begin
        if (accept) begin
          sum_d = sum_nx;
          if (sum_nx == 8'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            run_d   = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset also drops any write staged for the next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sum_q     <= 8'd0;
      idx_q     <= 9'd0;
      n_q       <= 9'd0;
      hi_q      <= 4'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      hi_q      <= hi_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      run_q     <= run_d;
    end
  end

  assign in_ready = in_session;
  assign busy     = in_session;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign err      = err_q;
  assign core_run = run_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        core_run;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  wa_log[$];
  logic [11:0] wd_log[$];
  int          done_cnt;

  program_loader #(.ADDR_W(2), .INSTR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .core_run(core_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record memory writes and done pulses mid-cycle
  always @(negedge clk) begin
    if (wr_en) begin
      wa_log.push_back(wr_addr);
      wd_log.push_back(wr_data);
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_log.delete();
    wd_log.delete();
    done_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err, core_run} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0",
               {in_ready, wr_en, wr_addr, wr_data, busy, done, err, core_run});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset busy=%b in_ready=%b want 0/0", busy, in_ready);
    end
  endtask

  task automatic test_good_frame();
    clear_log();
    do_start();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy busy=%b in_ready=%b want 1/1", busy, in_ready);
    end
    send_byte(8'h02); send_byte(8'h03); send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h44);
    n_checks++;
    if (done !== 1'b1 || core_run !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL good_end done=%b run=%b err=%b busy=%b rdy=%b want 1/1/0/0/0",
               done, core_run, err, busy, in_ready);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || core_run !== 1'b1 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL good_pulse done=%b run=%b done_cnt=%0d want 0/1/1", done, core_run, done_cnt);
    end
    n_checks++;
    if (wa_log.size() != 2 || wa_log[0] !== 2'd0 || wd_log[0] !== 12'h3A5 ||
        wa_log[1] !== 2'd1 || wd_log[1] !== 12'h012) begin
      n_fail++;
      $display("FAIL good_writes count=%0d want 2 writes (0,3a5),(1,012)", wa_log.size());
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    do_start();
    n_checks++;
    if (core_run !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clears_run run=%b want 0", core_run);
    end
    send_byte(8'h02); send_byte(8'h03); send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h45);
    tick();
    n_checks++;
    if (err !== 1'b1 || core_run !== 1'b0 || done_cnt != 0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL badck_end err=%b run=%b done_cnt=%0d rdy=%b want 1/0/0/0",
               err, core_run, done_cnt, in_ready);
    end
    n_checks++;
    if (wa_log.size() != 2 || wd_log[0] !== 12'h3A5 || wd_log[1] !== 12'h012) begin
      n_fail++;
      $display("FAIL badck_writes count=%0d want 2", wa_log.size());
    end
    do_start();
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_clears_err err=%b busy=%b want 0/1", err, busy);
    end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFF);
    n_checks++;
    if (core_run !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_after_err run=%b err=%b want 1/0", core_run, err);
    end
  endtask

  task automatic test_bad_header();
    clear_log();
    do_start();
    send_byte(8'h05);
    n_checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || core_run !== 1'b0) begin
      n_fail++;
      $display("FAIL hdr_05 err=%b rdy=%b busy=%b run=%b want 1/0/0/0", err, in_ready, busy, core_run);
    end
    do_start();
    send_byte(8'h00);
    n_checks++;
    if (err !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hdr_00 err=%b rdy=%b want 1/0", err, in_ready);
    end
    tick();
    n_checks++;
    if (wa_log.size() != 0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL hdr_nowrite writes=%0d err=%b want 0/1", wa_log.size(), err);
    end
  endtask

  task automatic test_bad_hi();
    clear_log();
    do_start();
    send_byte(8'h01);
    send_byte(8'h13);
    n_checks++;
    if (err !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_hi err=%b rdy=%b want 1/0", err, in_ready);
    end
    send_byte(8'hFF);
    tick();
    n_checks++;
    if (wa_log.size() != 0) begin
      n_fail++;
      $display("FAIL bad_hi_nowrite writes=%0d want 0", wa_log.size());
    end
  endtask

  task automatic test_full_depth_stall();
    logic [7:0] frame [10];
    logic [11:0] exp_d [4];
    frame = '{8'h04, 8'h01, 8'hAB, 8'h00, 8'h2C, 8'h0F, 8'h00, 8'h07, 8'h77, 8'h97};
    exp_d = '{12'h1AB, 12'h02C, 12'hF00, 12'h777};
    clear_log();
    do_start();
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'h5A;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || err !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold byte=%0d rdy=%b err=%b want 1/0", i, in_ready, err);
        end
      end
      send_byte(frame[i]);
    end
    tick();
    n_checks++;
    if (core_run !== 1'b1 || done_cnt != 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end run=%b done_cnt=%0d err=%b want 1/1/0", core_run, done_cnt, err);
    end
    n_checks++;
    if (wa_log.size() != 4) begin
      n_fail++;
      $display("FAIL full_count got=%0d want 4", wa_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (wa_log[k] !== 2'(k) || wd_log[k] !== exp_d[k]) begin
          n_fail++;
          $display("FAIL full_write%0d got=(%0d,%h) want=(%0d,%h)", k, wa_log[k], wd_log[k], k, exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_start();
    send_byte(8'h02); send_byte(8'h03); send_byte(8'hA5);
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err, core_run} !== 19'd0) begin
      n_fail++;
      $display("FAIL midframe_reset got=%h want=0",
               {in_ready, wr_en, wr_addr, wr_data, busy, done, err, core_run});
    end
    rst_n = 1'b1;
    tick();
    clear_log();
    do_start();
    send_byte(8'h02); send_byte(8'h03); send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h44);
    tick();
    n_checks++;
    if (core_run !== 1'b1 || done_cnt != 1 || wa_log.size() != 2 ||
        wd_log[0] !== 12'h3A5 || wa_log[1] !== 2'd1 || wd_log[1] !== 12'h012) begin
      n_fail++;
      $display("FAIL reload_after_reset run=%b done_cnt=%0d writes=%0d want 1/1/2",
               core_run, done_cnt, wa_log.size());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    done_cnt = 0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_header();
    test_bad_hi();
    test_full_depth_stall();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
